instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage upstream of the instruction register and control unit. Owns the program counter. Issues word reads to instruction memory over a req/ack handshake and buffers returned words in a small prefetch FIFO. Presents instructions to decode with valid/ready and supports a redirect input for future jump/branch instructions.

Parameters:
DEPTH, 2, prefetch FIFO entries; power of 2, minimum 2
RESET_ADDR, 32'h0000_0000, PC value after reset; word aligned
ADDR_W, 32, address/PC width
INSTR_W, 32, instruction width

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  read address; word aligned
imem_ack  in  1  read data valid; meaningful only while imem_req=1
imem_rdata  in  INSTR_W  instruction word; sampled when imem_req&imem_ack
instr  out  INSTR_W  instruction at FIFO head
instr_pc  out  ADDR_W  address of instr
instr_valid  out  1  FIFO non-empty
instr_ready  in  1  decode accepts instr this cycle
redirect_en  in  1  discard prefetched work and restart at redirect_addr
redirect_addr  in  ADDR_W  new fetch address; bits [1:0] forced to 0

Behaviour:
- Reset, sampled at posedge: imem_req=0, imem_addr=RESET_ADDR, FIFO empty, instr_valid=0, pc=RESET_ADDR, state=IDLE. Reset overrides every other input, including an ack in the same cycle.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: request outstanding, response will be discarded.
- IDLE -> WAIT when FIFO has space. Registered outputs: imem_req=1, imem_addr=pc.
- Handshake: once imem_req=1, imem_req and imem_addr hold stable until a cycle with imem_ack=1. Acks while imem_req=0 are ignored.
- WAIT & ack:
  - Push {imem_rdata, imem_addr}; pc += 4 (mod 2^32).
  - If free slots after this push and any same-cycle pop >= 1: stay WAIT, req=1, addr=pc+4. This gives back-to-back fetch.
  - Otherwise go to IDLE with req=0.
- Zero-wait memory: first instr_valid=1 two cycles after reset deasserts. Sustained throughput is 1 instruction/cycle.
- Pop when instr_valid&instr_ready. Push and pop in the same cycle is legal at any occupancy, including full; count is unchanged.
- instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
- redirect_en has priority below reset and above all else:
  - Flush FIFO; instr_valid=0 next cycle. A same-cycle pop still counts as consumed by decode.
  - pc <= {redirect_addr[ADDR_W-1:2],2'b00}.
  - From IDLE: next cycle req=1, addr=target, state WAIT.
  - From WAIT without ack: go to DROP; req/addr unchanged until ack.
  - From WAIT with ack: rdata discarded; next cycle req=1, addr=target.
  - From DROP: update target only.
- DROP & ack: discard data; next cycle req=1, addr=pc; go to WAIT.
- No stall or flush input other than instr_ready and redirect_en.
- Memory is reset by the same reset, so an abandoned request never acks after reset.

Decomposition:
- Shared package cpu_pkg: ADDR_W, INSTR_W, PC_STEP=4, and the fetch state enum {IDLE, WAIT, DROP}.
- One sub-module, fetch_fifo: synchronous FIFO of DEPTH entries of {instr, pc}, with push, pop, flush, count, full and empty.
  - Flush has priority over push.
  - Pop and push in the same cycle are supported when full.

Test Plan:
1. Reset, then zero-wait memory (ack=1 whenever req=1), instr_ready=1 -> imem_addr 0,4,8,12 on consecutive cycles; instr_valid from cycle 2; instr_pc 0,4,8 with matching words.
2. Zero-wait memory, instr_ready=0 -> after two acks imem_req=0, FIFO holds pc 0 and 4. Raise ready -> pops in order, then req resumes at addr 8.
3. Memory with 3-cycle ack latency -> imem_addr stable through wait cycles; instr_pc sequence 0,4,8 with no duplicates or gaps.
4. Redirect to 0x40 while WAIT on addr 8, ack arrives 2 cycles later -> that word is discarded; next req addr 0x40; first post-redirect instr_pc=0x40; no stale entries.
5. Redirect to 0x43 in the same cycle as ack and pop, FIFO full -> FIFO empty next cycle; next req addr 0x40; popped entry delivered exactly once.
6. Assert reset mid-WAIT with ack=1 the same cycle -> next cycle imem_req=0, instr_valid=0, imem_addr=RESET_ADDR; refetch starts at 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: bus widths, PC increment, fetch FSM states and prefetch entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    IDLE,  // no memory request outstanding
    WAIT,  // request outstanding, response will be kept
    DROP   // request outstanding, response will be thrown away
  } fetch_state_t;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundles the fetch stage's instruction-memory, decode and redirect signals.
// Latency: n/a (wires only).
// Backpressure: imem_req/imem_ack handshake toward memory, instr_valid/instr_ready toward decode.
// Ports: imem_req/imem_addr/imem_ack/imem_rdata (memory side),
//        instr/instr_pc/instr_valid/instr_ready (decode side), redirect_en/redirect_addr.
interface instruction_fetch_if
  import cpu_pkg::*;
  ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  logic               redirect_en;
  logic [ADDR_W-1:0]  redirect_addr;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redirect_en, redirect_addr
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redirect_en, redirect_addr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries with flush; head is presented combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens the same cycle; flush beats push.
// Ports: clk, reset, push/push_dat, pop, flush, head_dat, count, full, empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_dat,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot this cycle, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory and queues words for decode.
// Latency: with a zero-wait memory the first instr_valid is two cycles after reset; 1 instr/cycle sustained.
// Backpressure: stops requesting when the prefetch FIFO fills; instr held stable while instr_ready=0.
// Ports: clk, reset (sync, active high), bus (instruction_fetch_if.master).
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_fetch_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              req_q, req_n;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              ack;
  logic              room_after_push;
  logic [ADDR_W-1:0] target;
  fetch_entry_t      push_dat;
  fetch_entry_t      head_dat;

  // Acks only count while a request is actually on the bus.
  assign ack    = req_q & bus.imem_ack;
  assign pop    = ~fifo_empty & bus.instr_ready;
  assign target = word_align(bus.redirect_addr);

  // A redirect in the same cycle as the ack makes that word stale.
  assign push     = (state == WAIT) & ack & ~bus.redirect_en;
  assign push_dat = {bus.imem_rdata, addr_q};

  // Whether a slot remains once this cycle's push (and any pop) has landed.
  assign room_after_push = pop ? (fifo_count < CNT_W'(DEPTH))
                               : (fifo_count < CNT_W'(DEPTH - 1));

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (bus.redirect_en),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_ADDR;
      req_q  <= 1'b0;
      addr_q <= RESET_ADDR;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_q  <= req_n;
      addr_q <= addr_n;
    end
  end

  // pc is the address of the outstanding request in WAIT, and the next address
  // to fetch in IDLE/DROP.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = req_q;
    addr_n  = addr_q;
    case (state)
      IDLE: begin
        if (bus.redirect_en) begin
          state_n = WAIT;
          pc_n    = target;
          req_n   = 1'b1;
          addr_n  = target;
        end else if (!fifo_full) begin
          state_n = WAIT;
          req_n   = 1'b1;
          addr_n  = pc;
        end
      end
      WAIT: begin
        if (bus.redirect_en) begin
          pc_n = target;
          // The in-flight request cannot be withdrawn; without an ack we must
          // ride it out in DROP before fetching the new target.
          if (ack) addr_n  = target;
          else     state_n = DROP;
        end else if (ack) begin
          pc_n = pc + PC_STEP;
          if (room_after_push) begin
            addr_n = pc + PC_STEP;
          end else begin
            state_n = IDLE;
            req_n   = 1'b0;
          end
        end
      end
      DROP: begin
        if (bus.redirect_en) pc_n = target;
        if (ack) begin
          state_n = WAIT;
          addr_n  = bus.redirect_en ? target : pc;
        end
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = head_dat.instr;
  assign bus.instr_pc    = head_dat.pc;
  assign bus.instr_valid = ~fifo_empty;

endmodule
